// File: rtl/cache_pkg.sv
// Shared constants and helpers for the set-associative read cache.
// State codes, derived field widths and address field extraction live here
// so the top level and any future users agree on the address split.
package cache_pkg;

    localparam logic [2:0] S_INIT   = 3'd0;
    localparam logic [2:0] S_IDLE   = 3'd1;
    localparam logic [2:0] S_LOOKUP = 3'd2;
    localparam logic [2:0] S_MISS   = 3'd3;
    localparam logic [2:0] S_FILL   = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    // Way/pointer index width; a direct-mapped cache still needs a 1-bit index
    function automatic int ptrWidth(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

    // Tag bits are whatever remains of the covered address above set and word
    function automatic int tagWidth(input int cacheAddrW, input int setsLog2, input int burstLog2);
        return cacheAddrW - setsLog2 - burstLog2 - 1;
    endfunction

    function automatic logic [31:0] fieldOf(input logic [31:0] addr, input int lsb, input int width);
        return (addr >> lsb) & ((32'd1 << width) - 32'd1);
    endfunction

    function automatic logic [31:0] wordOf(input logic [31:0] addr, input int burstLog2);
        return fieldOf(addr, 1, burstLog2);
    endfunction

    function automatic logic [31:0] setOf(input logic [31:0] addr, input int setsLog2, input int burstLog2);
        return fieldOf(addr, burstLog2 + 1, setsLog2);
    endfunction

    function automatic logic [31:0] tagOf(input logic [31:0] addr, input int setsLog2, input int burstLog2,
                                          input int tagW);
        return fieldOf(addr, setsLog2 + burstLog2 + 1, tagW);
    endfunction

endpackage

// File: rtl/set_assoc_read_cache_if.sv
// CPU-side and SDRAM-side bus of the read cache.
// The master modport is the environment (CPU plus SDRAM controller),
// the slave modport is the cache itself.
interface set_assoc_read_cache_if;

    logic [31:0] cpu_addr;
    logic        cpu_req;
    logic        cpu_rw;
    logic        cpu_rwl;
    logic        cpu_rwu;
    logic [15:0] data_from_cpu;
    logic [15:0] data_to_cpu;
    logic        cpu_ack;

    logic [31:0] sdram_addr;
    logic        sdram_req;
    logic        sdram_rw;
    logic [15:0] data_from_sdram;
    logic        sdram_fill;

    modport master (
        output cpu_addr, cpu_req, cpu_rw, cpu_rwl, cpu_rwu, data_from_cpu,
        output data_from_sdram, sdram_fill,
        input  data_to_cpu, cpu_ack, sdram_addr, sdram_req, sdram_rw
    );

    modport slave (
        input  cpu_addr, cpu_req, cpu_rw, cpu_rwl, cpu_rwu, data_from_cpu,
        input  data_from_sdram, sdram_fill,
        output data_to_cpu, cpu_ack, sdram_addr, sdram_req, sdram_rw
    );

endinterface

// File: rtl/cache_way_ram.sv
// Data store for one cache way: 16-bit words, byte-lane write enables,
// registered (synchronous) read so it maps onto block RAM.
module cache_way_ram #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [1:0]        i_we,
    input  logic [15:0]       i_wdata,
    output logic [15:0]       o_rdata
);

    logic [15:0] r_mem [0:(1<<ADDR_W)-1];

    // Byte-lane writes and a read-before-write registered read port
    always_ff @(posedge clk) begin
        if (i_we[0]) r_mem[i_addr][7:0]  <= i_wdata[7:0];
        if (i_we[1]) r_mem[i_addr][15:8] <= i_wdata[15:8];
        o_rdata <= r_mem[i_addr];
    end

endmodule

// File: rtl/set_assoc_read_cache.sv
// N-way set-associative read cache between a 16-bit CPU port and a burst
// SDRAM controller. Read misses fill critical word first; write hits update
// the cached word in place; replacement prefers invalid ways, then a per-set
// round-robin pointer. A flush request is deferred until the controller is
// idle so an in-flight fill always completes.
module set_assoc_read_cache
    import cache_pkg::*;
#(
    parameter int WAYS         = 2,
    parameter int SETS_LOG2    = 8,
    parameter int BURST_LOG2   = 2,
    parameter int CACHE_ADDR_W = 26
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    output logic                  ready,
    set_assoc_read_cache_if.slave bus
);

    localparam int TAG_W  = tagWidth(CACHE_ADDR_W, SETS_LOG2, BURST_LOG2);
    localparam int IDX_W  = SETS_LOG2;
    localparam int WORD_W = BURST_LOG2;
    localparam int PTR_W  = ptrWidth(WAYS);
    localparam int SETS   = 1 << SETS_LOG2;
    localparam int RAM_AW = SETS_LOG2 + BURST_LOG2;

    logic [2:0]        r_state;
    logic [IDX_W-1:0]  r_initCnt;
    logic              r_flushPend;
    logic [31:0]       r_addr;
    logic              r_rw;
    logic [1:0]        r_be;
    logic [15:0]       r_wdata;
    logic [PTR_W-1:0]  r_victim;
    logic [WORD_W-1:0] r_fillWord;
    logic [WORD_W-1:0] r_fillCnt;
    logic              r_ack;
    logic [15:0]       r_rdata;
    logic              r_sdramReq;
    logic [31:0]       r_sdramAddr;

    logic [TAG_W-1:0]  r_tag   [WAYS][SETS];
    logic              r_valid [WAYS][SETS];

    logic [IDX_W-1:0]  w_reqSet;
    logic [WORD_W-1:0] w_reqWord;
    logic [IDX_W-1:0]  w_set;
    logic [WORD_W-1:0] w_word;
    logic [TAG_W-1:0]  w_tag;
    logic              w_anyHit;
    logic [PTR_W-1:0]  w_hitWay;
    logic [15:0]       w_hitData;
    logic              w_haveInvalid;
    logic [PTR_W-1:0]  w_invalidWay;
    logic [PTR_W-1:0]  w_victim;
    logic [PTR_W-1:0]  w_ptr;
    logic              w_allocate;
    logic              w_fillLast;
    logic [RAM_AW-1:0] w_ramAddr;
    logic [15:0]       w_ramWdata;
    logic [1:0]        w_ramWe    [WAYS];
    logic [15:0]       w_ramRdata [WAYS];

    assign w_reqSet  = IDX_W'(setOf(bus.cpu_addr, SETS_LOG2, BURST_LOG2));
    assign w_reqWord = WORD_W'(wordOf(bus.cpu_addr, BURST_LOG2));
    assign w_set     = IDX_W'(setOf(r_addr, SETS_LOG2, BURST_LOG2));
    assign w_word    = WORD_W'(wordOf(r_addr, BURST_LOG2));
    assign w_tag     = TAG_W'(tagOf(r_addr, SETS_LOG2, BURST_LOG2, TAG_W));

    assign w_allocate = (r_state == S_LOOKUP) && r_rw && !w_anyHit;
    assign w_fillLast = (r_state == S_FILL) && (r_fillCnt == '1);

    assign ready            = (r_state != S_INIT);
    assign bus.cpu_ack      = r_ack;
    assign bus.data_to_cpu  = r_rdata;
    assign bus.sdram_req    = r_sdramReq;
    assign bus.sdram_addr   = r_sdramAddr;
    assign bus.sdram_rw     = 1'b1;

    // Tag compare for the latched set, hit-way data select and victim choice
    always_comb begin
        w_anyHit      = 1'b0;
        w_hitWay      = '0;
        w_hitData     = '0;
        w_haveInvalid = 1'b0;
        w_invalidWay  = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (r_valid[w][w_set] && (r_tag[w][w_set] == w_tag)) begin
                w_anyHit = 1'b1;
                w_hitWay = PTR_W'(w);
            end
            if (!r_valid[w][w_set]) begin
                w_haveInvalid = 1'b1;
                w_invalidWay  = PTR_W'(w);
            end
        end
        for (int w = 0; w < WAYS; w++) begin
            if (PTR_W'(w) == w_hitWay) w_hitData = w_ramRdata[w];
        end
        w_victim = w_haveInvalid ? w_invalidWay : w_ptr;
    end

    // Data RAM port steering: CPU address in IDLE, latched line otherwise
    always_comb begin
        w_ramAddr  = {w_reqSet, w_reqWord};
        w_ramWdata = r_wdata;
        for (int w = 0; w < WAYS; w++) w_ramWe[w] = 2'b00;
        case (r_state)
            S_LOOKUP: begin
                w_ramAddr = {w_set, w_word};
                for (int w = 0; w < WAYS; w++) begin
                    if (!r_rw && w_anyHit && (PTR_W'(w) == w_hitWay)) w_ramWe[w] = r_be;
                end
            end
            S_MISS: begin
                w_ramAddr  = {w_set, w_word};
                w_ramWdata = bus.data_from_sdram;
                for (int w = 0; w < WAYS; w++) begin
                    if (bus.sdram_fill && (PTR_W'(w) == r_victim)) w_ramWe[w] = 2'b11;
                end
            end
            S_FILL: begin
                w_ramAddr  = {w_set, r_fillWord};
                w_ramWdata = bus.data_from_sdram;
                for (int w = 0; w < WAYS; w++) begin
                    if (PTR_W'(w) == r_victim) w_ramWe[w] = 2'b11;
                end
            end
            default: begin
            end
        endcase
    end

    for (genvar g = 0; g < WAYS; g++) begin : g_way
        cache_way_ram #(.ADDR_W(RAM_AW)) u_ram (
            .clk     (clk),
            .i_addr  (w_ramAddr),
            .i_we    (w_ramWe[g]),
            .i_wdata (w_ramWdata),
            .o_rdata (w_ramRdata[g])
        );
    end

    // Round-robin pointer per set; only stored when there is a choice to make
    if (WAYS > 1) begin : g_ptr
        logic [PTR_W-1:0] r_ptr [SETS];

        // Cleared by the init sweep, advanced when a fill completes
        always_ff @(posedge clk) begin
            if (r_state == S_INIT) r_ptr[r_initCnt] <= '0;
            else if (w_fillLast)   r_ptr[w_set] <= r_ptr[w_set] + PTR_W'(1);
        end

        assign w_ptr = r_ptr[w_set];
    end else begin : g_noPtr
        assign w_ptr = '0;
    end

    // Line valid/tag bookkeeping: sweep clear, allocate on miss, validate on fill end
    always_ff @(posedge clk) begin
        for (int w = 0; w < WAYS; w++) begin
            if (r_state == S_INIT) begin
                r_valid[w][r_initCnt] <= 1'b0;
            end else if (w_allocate && (PTR_W'(w) == w_victim)) begin
                r_valid[w][w_set] <= 1'b0;
                r_tag[w][w_set]   <= w_tag;
            end else if (w_fillLast && (PTR_W'(w) == r_victim)) begin
                r_valid[w][w_set] <= 1'b1;
            end
        end
    end

    // Controller sequencing: init sweep, lookup, miss request, burst fill, completion
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_INIT;
            r_initCnt   <= '0;
            r_flushPend <= 1'b0;
            r_addr      <= '0;
            r_rw        <= 1'b1;
            r_be        <= 2'b00;
            r_wdata     <= '0;
            r_victim    <= '0;
            r_fillWord  <= '0;
            r_fillCnt   <= '0;
            r_ack       <= 1'b0;
            r_rdata     <= '0;
            r_sdramReq  <= 1'b0;
            r_sdramAddr <= '0;
        end else begin
            r_ack <= 1'b0;
            if (flush) r_flushPend <= 1'b1;
            case (r_state)
                S_INIT: begin
                    r_initCnt <= r_initCnt + IDX_W'(1);
                    if (r_initCnt == IDX_W'(SETS - 1)) r_state <= S_IDLE;
                end
                S_IDLE: begin
                    if (r_flushPend || flush) begin
                        r_flushPend <= 1'b0;
                        r_initCnt   <= '0;
                        r_state     <= S_INIT;
                    end else if (bus.cpu_req) begin
                        r_addr  <= bus.cpu_addr;
                        r_rw    <= bus.cpu_rw;
                        r_be    <= {bus.cpu_rwu, bus.cpu_rwl};
                        r_wdata <= bus.data_from_cpu;
                        r_state <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (r_rw && !w_anyHit) begin
                        r_victim    <= w_victim;
                        r_sdramAddr <= {r_addr[31:BURST_LOG2+1], {(BURST_LOG2+1){1'b0}}};
                        r_sdramReq  <= 1'b1;
                        r_state     <= S_MISS;
                    end else begin
                        r_ack <= 1'b1;
                        if (r_rw) r_rdata <= w_hitData;
                        r_state <= S_DONE;
                    end
                end
                S_MISS: begin
                    if (bus.sdram_fill) begin
                        r_sdramReq <= 1'b0;
                        r_rdata    <= bus.data_from_sdram;
                        r_ack      <= 1'b1;
                        r_fillWord <= w_word + WORD_W'(1);
                        r_fillCnt  <= WORD_W'(1);
                        r_state    <= S_FILL;
                    end
                end
                S_FILL: begin
                    r_fillWord <= r_fillWord + WORD_W'(1);
                    r_fillCnt  <= r_fillCnt + WORD_W'(1);
                    if (r_fillCnt == '1) r_state <= S_DONE;
                end
                S_DONE: begin
                    if (!bus.cpu_req) r_state <= S_IDLE;
                end
                default: r_state <= S_INIT;
            endcase
        end
    end

endmodule
